prog_run_sequencer: RTL and testbench

Hardware run sequencer between a host/bench stream and `top_level`:
- Streams a 33-byte program-3 image (32 message bytes plus the pattern byte) into data memory.
- Zeroes the three result bytes, pulses `Start`, and waits for `Done` under a timeout.
- Reads result bytes 33..35 back, compares them against expected counts, and reports pass/fail.

It owns the data-memory port only while loading, clearing and reading back. `top_level` owns it during the run.

---
 rtl/prog_run_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_prog_run_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_sequencer.sv
// Run sequencer: streams a program image into data memory, clears the result bytes,
// starts top_level, waits for Done under a timeout, then reads back and grades the results.
module prog_run_sequencer #(
  parameter int DM_AW       = 8,
  parameter int N_MSG       = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic [7:0]       ExpCtb,
  input  logic [7:0]       ExpCto,
  input  logic [7:0]       ExpCts,
  input  logic [7:0]       ImgByte,
  input  logic             ImgValid,
  output logic             ImgReady,
  output logic             MemOwn,
  output logic [DM_AW-1:0] DmAddr,
  output logic             DmWrEn,
  output logic [7:0]       DmWrData,
  input  logic [7:0]       DmRdData,
  output logic             Start,
  input  logic             Done,
  output logic             Busy,
  output logic             Pass,
  output logic             Fail,
  output logic             Timeout,
  output logic [2:0]       ErrMask
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DM_AW-1:0]  LAST_IDX  = DM_AW'(N_MSG);
  localparam logic [DM_AW-1:0]  RES_BASE  = DM_AW'(N_MSG + 1);
  localparam logic [WAIT_W-1:0] WAIT_TERM = WAIT_W'(TIMEOUT_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_START, S_RUN, S_READ, S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [DM_AW-1:0]  load_idx;
  logic [1:0]        sub_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              done_q;
  logic [7:0]        exp_ctb, exp_cto, exp_cts;
  logic              pass_r, fail_r, timeout_r;
  logic [2:0]        err_r;

  logic              go_acc;
  logic              done_rise;
  logic              last_sub;
  logic              wait_hit;
  logic [7:0]        rd_exp;
  logic [2:0]        rd_bit;
  logic [2:0]        err_nxt;

  // Counter saturates at terminal count so it can never wrap back into range.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (v == WAIT_TERM) return v;
    return v + 1'b1;
  endfunction

  function automatic logic byte_mismatch(input logic [7:0] a, input logic [7:0] b);
    return a != b;
  endfunction

  assign go_acc    = Go && (state == S_IDLE || state == S_REPORT);
  assign done_rise = Done && !done_q;
  assign last_sub  = (sub_cnt == 2'd2);
  assign wait_hit  = (wait_cnt == WAIT_LAST);

  always_comb begin
    rd_exp = exp_ctb;
    case (sub_cnt)
      2'd1:    rd_exp = exp_cto;
      2'd2:    rd_exp = exp_cts;
      default: rd_exp = exp_ctb;
    endcase
    rd_bit  = byte_mismatch(DmRdData, rd_exp) ? (3'b001 << sub_cnt) : 3'b000;
    err_nxt = err_r | rd_bit;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ImgReady  = 1'b0;
    MemOwn    = 1'b0;
    DmAddr    = '0;
    DmWrEn    = 1'b0;
    DmWrData  = '0;
    Start     = 1'b0;
    Busy      = 1'b0;
    case (state)
      S_IDLE, S_REPORT: begin
        if (go_acc) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        Busy     = 1'b1;
        ImgReady = 1'b1;
        MemOwn   = 1'b1;
        DmAddr   = load_idx;
        if (ImgValid) begin
          DmWrEn   = 1'b1;
          DmWrData = ImgByte;
          if (load_idx == LAST_IDX) state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        Busy   = 1'b1;
        MemOwn = 1'b1;
        DmAddr = RES_BASE + DM_AW'(sub_cnt);
        DmWrEn = 1'b1;
        if (last_sub) state_nxt = S_START;
      end
      S_START: begin
        Busy      = 1'b1;
        Start     = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (done_rise)     state_nxt = S_READ;
        else if (wait_hit) state_nxt = S_REPORT;
      end
      S_READ: begin
        Busy   = 1'b1;
        MemOwn = 1'b1;
        DmAddr = RES_BASE + DM_AW'(sub_cnt);
        if (last_sub) state_nxt = S_REPORT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Done history is tracked in every state so a level left high by a prior run is not an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_idx  <= '0;
      sub_cnt   <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
      err_r     <= '0;
    end else begin
      done_q <= Done;
      case (state)
        S_IDLE, S_REPORT: begin
          if (go_acc) begin
            load_idx  <= '0;
            sub_cnt   <= '0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_r     <= '0;
          end
        end
        S_LOAD: begin
          sub_cnt <= '0;
          if (ImgValid && load_idx != LAST_IDX) load_idx <= load_idx + 1'b1;
        end
        S_CLEAR: begin
          sub_cnt <= last_sub ? 2'd0 : sub_cnt + 2'd1;
        end
        S_START: begin
          wait_cnt <= '0;
        end
        S_RUN: begin
          sub_cnt  <= '0;
          wait_cnt <= sat_inc(wait_cnt);
          if (!done_rise && wait_hit) begin
            timeout_r <= 1'b1;
            fail_r    <= 1'b1;
          end
        end
        S_READ: begin
          err_r   <= err_nxt;
          sub_cnt <= last_sub ? 2'd0 : sub_cnt + 2'd1;
          if (last_sub) begin
            pass_r <= (err_nxt == 3'b000);
            fail_r <= (err_nxt != 3'b000);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (go_acc) begin
      exp_ctb <= ExpCtb;
      exp_cto <= ExpCto;
      exp_cts <= ExpCts;
    end
  end

  assign Pass    = pass_r;
  assign Fail    = fail_r;
  assign Timeout = timeout_r;
  assign ErrMask = err_r;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Directed bench for prog_run_sequencer: table of full runs against a behavioural
// memory plus top_level stub, and hand-written sequences for Done-level and reset cases.
module tb_prog_run_sequencer;

  localparam int DM_AW = 8;
  localparam int N_MSG = 32;
  localparam int TO    = 200;

  logic             Clk = 1'b0;
  logic             Reset, Go;
  logic [7:0]       ExpCtb, ExpCto, ExpCts, ImgByte;
  logic             ImgValid, ImgReady, MemOwn;
  logic [DM_AW-1:0] DmAddr;
  logic             DmWrEn;
  logic [7:0]       DmWrData, DmRdData;
  logic             Start, Done, Busy, Pass, Fail, Timeout;
  logic [2:0]       ErrMask;

  always #5 Clk = ~Clk;

  prog_run_sequencer #(.DM_AW(DM_AW), .N_MSG(N_MSG), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go),
    .ExpCtb(ExpCtb), .ExpCto(ExpCto), .ExpCts(ExpCts),
    .ImgByte(ImgByte), .ImgValid(ImgValid), .ImgReady(ImgReady),
    .MemOwn(MemOwn), .DmAddr(DmAddr), .DmWrEn(DmWrEn), .DmWrData(DmWrData),
    .DmRdData(DmRdData), .Start(Start), .Done(Done), .Busy(Busy),
    .Pass(Pass), .Fail(Fail), .Timeout(Timeout), .ErrMask(ErrMask)
  );

  // Data memory and top_level stub
  logic [7:0] mem [0:255];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];
  bit         stub_en, stub_done_en;
  int         stub_delay;
  logic [7:0] stub_v0, stub_v1, stub_v2;
  bit         stub_active;
  int         stub_cnt;
  logic       stub_done;
  logic       done_force;

  assign DmRdData = mem[DmAddr];
  assign Done     = stub_done | done_force;

  always @(posedge Clk) begin
    if (MemOwn && DmWrEn) begin
      mem[DmAddr] <= DmWrData;
      wr_addr.push_back(DmAddr);
      wr_data.push_back(DmWrData);
    end
    if (Reset) begin
      stub_active <= 1'b0;
      stub_done   <= 1'b0;
    end else if (Start) begin
      stub_done   <= 1'b0;
      stub_active <= stub_en;
      stub_cnt    <= 1;
    end else if (stub_active) begin
      if (stub_cnt == stub_delay) begin
        stub_active <= 1'b0;
        mem[33]     <= stub_v0;
        mem[34]     <= stub_v1;
        mem[35]     <= stub_v2;
        stub_done   <= stub_done_en;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [7:0] msg, pat, e0, e1, e2, s0, s1, s2;
    int         delay;
    bit         done_en, toggle, ramp;
    bit         x_pass, x_fail, x_to;
    logic [2:0] x_err;
  } vec_t;

  vec_t tbl [5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img_byte(input vec_t v, input int i);
    if (i == N_MSG) return v.pat;
    return v.ramp ? v.msg + 8'(i) : v.msg;
  endfunction

  task automatic pulse_go(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    @(negedge Clk);
    Go = 1'b1; ExpCtb = e0; ExpCto = e1; ExpCts = e2;
    @(negedge Clk);
    Go = 1'b0; ExpCtb = 8'hEE; ExpCto = 8'hEE; ExpCts = 8'hEE;
  endtask

  task automatic feed(input vec_t v);
    for (int i = 0; i <= N_MSG; i++) begin
      if (v.toggle) begin
        ImgValid = 1'b0;
        @(negedge Clk);
      end
      ImgValid = 1'b1;
      ImgByte  = img_byte(v, i);
      @(negedge Clk);
    end
    ImgValid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Busy && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    chk(tag, "busy_end", Busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base, k, start_k, starts, reads, bad, bad_img;
    stub_en = 1'b1; stub_delay = v.delay; stub_done_en = v.done_en;
    stub_v0 = v.s0; stub_v1 = v.s1; stub_v2 = v.s2;
    base = wr_addr.size();
    pulse_go(v.e0, v.e1, v.e2);
    chk(tag, "busy_go", Busy, 1);
    chk(tag, "rdy_go", ImgReady, 1);
    feed(v);
    k = 0; start_k = -1; starts = 0; reads = 0;
    while (Busy && k < 2000) begin
      if (Start) begin
        starts++;
        if (start_k < 0) start_k = k;
      end
      if (MemOwn && !DmWrEn && !ImgReady) reads++;
      @(negedge Clk);
      k++;
    end
    chk(tag, "busy_end", Busy, 0);
    chk(tag, "pass", Pass, v.x_pass);
    chk(tag, "fail", Fail, v.x_fail);
    chk(tag, "timeout", Timeout, v.x_to);
    chk(tag, "errmask", ErrMask, v.x_err);
    chk(tag, "starts", starts, 1);
    chk(tag, "reads", reads, v.x_to ? 0 : 3);
    if (v.x_to) chk(tag, "to_latency", k - start_k, TO + 1);
    chk(tag, "n_writes", wr_addr.size() - base, 36);
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      if (base + i >= wr_addr.size()) bad++;
      else if (wr_addr[base + i] != 8'(i)) bad++;
      else if (i > N_MSG && wr_data[base + i] != 8'h00) bad++;
    end
    chk(tag, "wr_order", bad, 0);
    bad_img = 0;
    for (int i = 0; i <= N_MSG; i++)
      if (mem[i] != img_byte(v, i)) bad_img++;
    chk(tag, "image", bad_img, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, starts;
    vec_t vh;
    //        msg    pat    e0  e1  e2   s0  s1  s2   dly don tog rmp  pass fail to  err
    tbl[0] = '{8'h55, 8'hA8, 64, 32, 126, 64, 32, 126, 50, 1,  0,  0,   1,   0,  0, 3'b000};
    tbl[1] = '{8'h55, 8'hA8, 64, 32, 126, 64, 31, 126, 50, 1,  0,  0,   0,   1,  0, 3'b010};
    tbl[2] = '{8'h55, 8'hA8, 64, 32, 126, 64, 32, 126, 50, 0,  0,  0,   0,   1,  1, 3'b000};
    tbl[3] = '{8'h3C, 8'h07, 1,  2,  3,   1,  2,  3,   20, 1,  1,  1,   1,   0,  0, 3'b000};
    tbl[4] = '{8'hC3, 8'h00, 10, 20, 30,  11, 20, 31,  5,  1,  0,  1,   0,   1,  0, 3'b101};

    Reset = 1'b1; Go = 1'b0; ImgValid = 1'b0; ImgByte = 8'h00;
    ExpCtb = 8'h00; ExpCto = 8'h00; ExpCts = 8'h00;
    done_force = 1'b0; stub_en = 1'b0; stub_done_en = 1'b0; stub_delay = 1;
    stub_v0 = 8'h00; stub_v1 = 8'h00; stub_v2 = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset", "outputs", int'({ImgReady, MemOwn, DmAddr, DmWrEn, DmWrData, Start,
                                  Busy, Pass, Fail, Timeout, ErrMask}), 0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Done held high across START: only a fresh rising edge in RUN may end the run.
    vh = tbl[0];
    vh.e0 = 0; vh.e1 = 0; vh.e2 = 0;
    stub_en = 1'b0;
    done_force = 1'b1;
    pulse_go(8'h00, 8'h00, 8'h00);
    feed(vh);
    k = 0;
    while (!Start && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("done_lvl", "saw_start", Start, 1);
    repeat (5) @(negedge Clk);
    done_force = 1'b0;
    repeat (5) @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    chk("done_lvl", "go_ignored", ImgReady, 0);
    repeat (9) @(negedge Clk);
    chk("done_lvl", "still_run", int'({MemOwn, Busy}), 1);
    done_force = 1'b1;
    @(negedge Clk);
    chk("done_lvl", "read_own", MemOwn, 1);
    chk("done_lvl", "read_addr", DmAddr, 33);
    wait_idle("done_lvl");
    chk("done_lvl", "pass", Pass, 1);
    chk("done_lvl", "errmask", ErrMask, 0);
    done_force = 1'b0;

    // Reset ten cycles into RUN aborts the sequence.
    stub_en = 1'b1; stub_delay = 50; stub_done_en = 1'b1;
    stub_v0 = 64; stub_v1 = 32; stub_v2 = 126;
    pulse_go(64, 32, 126);
    feed(tbl[0]);
    k = 0;
    while (!Start && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("rst_run", "saw_start", Start, 1);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_run", "outputs", int'({ImgReady, MemOwn, DmAddr, DmWrEn, DmWrData, Start,
                                   Busy, Pass, Fail, Timeout, ErrMask}), 0);
    Reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 80; i++) begin
      if (Start) starts++;
      @(negedge Clk);
    end
    chk("rst_run", "no_start", starts, 0);
    chk("rst_run", "idle", Busy, 0);
    run_vec(tbl[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
